// File: rtl/dco_tune_ctrl.sv
// DCO frequency-lock controller: counts dco_in toggles over a fixed window and nudges the tuning word toward the target.
// Loop period is SETTLE_CYC + 2^WIN_LOG2 + 1 cycles; configuration is accepted only while idle (cfg_ready).
module dco_tune_ctrl #(
  parameter int WIN_LOG2   = 10,
  parameter int TOL        = 2,
  parameter int LOCK_CNT   = 4,
  parameter int STEP_MAX   = 4096,
  parameter int SETTLE_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [23:0] cfg_mod,
  input  logic [23:0] cfg_init_speed,
  input  logic [15:0] cfg_target,
  input  logic        stop,
  input  logic        dco_in,
  output logic [23:0] speed_var,
  output logic [23:0] mod,
  output logic        locked,
  output logic        busy,
  output logic        err_rail
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int LW = $clog2(LOCK_CNT + 1);

  localparam logic [SW-1:0]       SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [WIN_LOG2-1:0] WIN_LAST    = '1;
  localparam logic [LW-1:0]       LOCK_MAX    = LW'(LOCK_CNT);
  localparam logic [16:0]         TOL_V       = 17'(TOL);
  localparam logic signed [16:0]  STEP_P      = 17'(STEP_MAX);
  localparam logic signed [16:0]  STEP_N      = -STEP_P;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_MEASURE = 2'd2,
    ST_ADJUST  = 2'd3
  } state_t;

  state_t              r_state;
  logic [23:0]         r_speed;
  logic [23:0]         r_mod;
  logic [15:0]         r_target;
  logic                r_locked;
  logic                r_err_rail;
  logic                r_cfg_ready;
  logic                r_busy;
  logic [LW-1:0]       r_lock_cnt;
  logic [SW-1:0]       r_settle_cnt;
  logic [WIN_LOG2-1:0] r_win_cnt;
  logic [15:0]         r_edge_cnt;
  logic                r_dco_d;

  logic signed [16:0]  w_err;
  logic [16:0]         w_err_abs;
  logic                w_in_tol;
  logic signed [16:0]  w_step;
  logic signed [25:0]  w_sum;
  logic                w_rail_hi;
  logic                w_rail_lo;
  logic [23:0]         w_new_speed;
  logic [LW-1:0]       w_lock_inc;
  logic                w_toggle;

  assign w_err     = $signed({1'b0, r_target}) - $signed({1'b0, r_edge_cnt});
  assign w_err_abs = w_err[16] ? (17'd0 - w_err) : w_err;
  assign w_in_tol  = (w_err_abs <= TOL_V);

  always_comb begin
    w_step = w_err;
    if (w_err > STEP_P) begin
      w_step = STEP_P;
    end else if (w_err < STEP_N) begin
      w_step = STEP_N;
    end
  end

  // 26-bit signed sum leaves headroom so both rails are detected before truncation.
  assign w_sum       = $signed({2'b00, r_speed}) + $signed({{9{w_step[16]}}, w_step});
  assign w_rail_hi   = (w_sum > 26'sh0FFFFFF);
  assign w_rail_lo   = (w_sum < 26'sd1);
  assign w_new_speed = w_rail_hi ? 24'hFFFFFF : (w_rail_lo ? 24'd1 : w_sum[23:0]);

  assign w_lock_inc = (r_lock_cnt == LOCK_MAX) ? LOCK_MAX : (r_lock_cnt + LW'(1));
  assign w_toggle   = dco_in ^ r_dco_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_speed      <= '0;
      r_mod        <= '0;
      r_target     <= '0;
      r_locked     <= 1'b0;
      r_err_rail   <= 1'b0;
      r_cfg_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_lock_cnt   <= '0;
      r_settle_cnt <= '0;
      r_win_cnt    <= '0;
      r_edge_cnt   <= '0;
      r_dco_d      <= 1'b0;
    end else begin
      r_dco_d <= dco_in;
      if (stop && (r_state != ST_IDLE)) begin
        // Abort keeps the last tuning word so the DCO stays where it was.
        r_state     <= ST_IDLE;
        r_cfg_ready <= 1'b1;
        r_busy      <= 1'b0;
        r_locked    <= 1'b0;
        r_lock_cnt  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (cfg_valid && r_cfg_ready) begin
              r_mod        <= cfg_mod;
              r_speed      <= cfg_init_speed;
              r_target     <= cfg_target;
              r_locked     <= 1'b0;
              r_err_rail   <= 1'b0;
              r_lock_cnt   <= '0;
              r_settle_cnt <= '0;
              r_state      <= ST_SETTLE;
              r_cfg_ready  <= 1'b0;
              r_busy       <= 1'b1;
            end
          end
          ST_SETTLE: begin
            if (r_settle_cnt == SETTLE_LAST) begin
              r_state    <= ST_MEASURE;
              r_edge_cnt <= '0;
              r_win_cnt  <= '0;
            end else begin
              r_settle_cnt <= r_settle_cnt + SW'(1);
            end
          end
          ST_MEASURE: begin
            if (w_toggle && (r_edge_cnt != 16'hFFFF)) begin
              r_edge_cnt <= r_edge_cnt + 16'd1;
            end
            r_win_cnt <= r_win_cnt + WIN_LOG2'(1);
            if (r_win_cnt == WIN_LAST) begin
              r_state <= ST_ADJUST;
            end
          end
          ST_ADJUST: begin
            if (w_in_tol) begin
              r_lock_cnt <= w_lock_inc;
              if (w_lock_inc == LOCK_MAX) begin
                r_locked <= 1'b1;
              end
            end else begin
              r_lock_cnt <= '0;
              r_locked   <= 1'b0;
              r_speed    <= w_new_speed;
              if (w_rail_hi || w_rail_lo) begin
                r_err_rail <= 1'b1;
              end
            end
            r_settle_cnt <= '0;
            r_state      <= ST_SETTLE;
          end
          default: begin
            r_state     <= ST_IDLE;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign busy      = r_busy;
  assign speed_var = r_speed;
  assign mod       = r_mod;
  assign locked    = r_locked;
  assign err_rail  = r_err_rail;

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// Bench for dco_tune_ctrl: directed loop scenarios plus randomized targets/speeds against an arithmetic loop model.
module tb_dco_tune_ctrl;

  localparam int LOOP = 16 + 1024 + 1;

  logic        clk;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [23:0] cfg_mod;
  logic [23:0] cfg_init_speed;
  logic [15:0] cfg_target;
  logic        stop;
  logic        dco_in;
  logic [23:0] speed_var;
  logic [23:0] mod;
  logic        locked;
  logic        busy;
  logic        err_rail;

  int n_assert = 0;
  int n_fail   = 0;
  int tog_per  = 8;

  int p, cnt, tgt, spd, inl, err, step;
  bit lk, rl;

  dco_tune_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_mod       (cfg_mod),
    .cfg_init_speed(cfg_init_speed),
    .cfg_target    (cfg_target),
    .stop          (stop),
    .dco_in        (dco_in),
    .speed_var     (speed_var),
    .mod           (mod),
    .locked        (locked),
    .busy          (busy),
    .err_rail      (err_rail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dco_in flips once every tog_per clk cycles, shortly after the edge.
  initial begin
    int cyc;
    cyc = 0;
    dco_in = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      if (cyc >= tog_per) begin
        cyc = 0;
        #1 dco_in = ~dco_in;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [23:0] m, input logic [23:0] s, input logic [15:0] t);
    cfg_mod        = m;
    cfg_init_speed = s;
    cfg_target     = t;
    cfg_valid      = 1'b1;
    tick(1);
    cfg_valid      = 1'b0;
  endtask

  task automatic abort_loop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    tick(2);
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; stop = 1'b0;
    cfg_mod = '0; cfg_init_speed = '0; cfg_target = '0;
    tick(3);
    check("rst_speed", speed_var, 0);
    check("rst_mod", mod, 0);
    check("rst_locked", locked, 0);
    check("rst_busy", busy, 0);
    check("rst_rail", err_rail, 0);
    check("rst_ready", cfg_ready, 1);
    cfg_mod = 24'h111111; cfg_init_speed = 24'h222; cfg_target = 16'd5; cfg_valid = 1'b1;
    tick(2);
    check("rst_no_accept_mod", mod, 0);
    check("rst_no_accept_busy", busy, 0);
    cfg_valid = 1'b0; rst = 1'b0;
    tick(2);

    // Lock: 128 toggles per window with target 128.
    accept(24'd1000, 24'd1000, 16'd128);
    check("acc_busy", busy, 1);
    check("acc_ready", cfg_ready, 0);
    check("acc_speed", speed_var, 1000);
    check("acc_mod", mod, 1000);
    tick(LOOP);
    check("lock_speed_l1", speed_var, 1000);
    check("lock_early_l1", locked, 0);
    tick(4 * LOOP - 1 - LOOP);
    check("lock_not_yet", locked, 0);
    tick(1);
    check("lock_set", locked, 1);
    check("lock_speed", speed_var, 1000);
    tick(LOOP);
    check("lock_held", locked, 1);
    abort_loop();
    check("lock_stop_locked", locked, 0);
    check("lock_stop_speed", speed_var, 1000);

    // Small step: err = +72.
    accept(24'd1000, 24'd1000, 16'd200);
    tick(LOOP - 1);
    check("small_pre", speed_var, 1000);
    tick(1);
    check("small_speed", speed_var, 1072);
    check("small_locked", locked, 0);
    tick(LOOP);
    check("small_speed_l2", speed_var, 1144);
    abort_loop();

    // Step clamp at +STEP_MAX.
    accept(24'd1000, 24'd1000, 16'd10000);
    tick(LOOP);
    check("clamp_speed", speed_var, 5096);
    check("clamp_rail", err_rail, 0);
    abort_loop();

    // Upper and lower rails.
    accept(24'd1000, 24'hFFFFF0, 16'd200);
    tick(LOOP);
    check("rail_hi_speed", speed_var, 24'hFFFFFF);
    check("rail_hi_flag", err_rail, 1);
    abort_loop();
    check("rail_hi_held", err_rail, 1);
    check("rail_hi_speed_held", speed_var, 24'hFFFFFF);
    accept(24'd1000, 24'd5, 16'd0);
    check("rail_clear_on_accept", err_rail, 0);
    tick(LOOP);
    check("rail_lo_speed", speed_var, 1);
    check("rail_lo_flag", err_rail, 1);
    abort_loop();

    // Abort during MEASURE, with an ignored config pulse.
    accept(24'h123456, 24'd3000, 16'd128);
    tick(100);
    cfg_mod = 24'hABCDEF; cfg_init_speed = 24'd7; cfg_target = 16'd9; cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
    check("ign_mod", mod, 24'h123456);
    check("ign_speed", speed_var, 3000);
    check("ign_busy", busy, 1);
    tick(516 - 101);
    check("abort_pre_busy", busy, 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_ready", cfg_ready, 1);
    check("abort_locked", locked, 0);
    check("abort_speed", speed_var, 3000);
    check("abort_mod", mod, 24'h123456);
    tick(2);

    // Reset while in ADJUST.
    accept(24'h55, 24'hFFFFF0, 16'd200);
    tick(LOOP - 1);
    rst = 1'b1;
    tick(1);
    check("mrst_speed", speed_var, 0);
    check("mrst_mod", mod, 0);
    check("mrst_busy", busy, 0);
    check("mrst_ready", cfg_ready, 1);
    check("mrst_rail", err_rail, 0);
    check("mrst_locked", locked, 0);
    cfg_valid = 1'b1;
    tick(2);
    check("mrst_no_accept", busy, 0);
    rst = 1'b0; cfg_valid = 1'b0;
    tick(2);

    // Randomized loops against an arithmetic reference.
    for (int it = 0; it < 6; it++) begin
      p = 2 << $urandom_range(0, 5);
      tog_per = p;
      tick(3 * 64);
      cnt = 1024 / p;
      case ($urandom_range(0, 2))
        0: tgt = cnt + int'($urandom_range(0, 4)) - 2;
        1: tgt = int'($urandom_range(0, 65535));
        default: tgt = cnt + int'($urandom_range(0, 200)) - 100;
      endcase
      if (tgt < 0) tgt = 0;
      case ($urandom_range(0, 2))
        0: spd = int'($urandom_range(1, 24'hFFFFFF));
        1: spd = int'($urandom_range(1, 3000));
        default: spd = 24'hFFFFFF - int'($urandom_range(0, 3000));
      endcase
      accept(24'(it + 1), 24'(spd), 16'(tgt));
      inl = 0; lk = 1'b0; rl = 1'b0;
      for (int k = 0; k < 5; k++) begin
        tick(LOOP);
        err = tgt - cnt;
        if (err >= -2 && err <= 2) begin
          if (inl < 4) inl++;
          if (inl == 4) lk = 1'b1;
        end else begin
          inl = 0;
          lk = 1'b0;
          step = (err > 4096) ? 4096 : ((err < -4096) ? -4096 : err);
          spd = spd + step;
          if (spd > 24'hFFFFFF) begin
            spd = 24'hFFFFFF; rl = 1'b1;
          end else if (spd < 1) begin
            spd = 1; rl = 1'b1;
          end
        end
        check("rnd_speed", speed_var, spd);
        check("rnd_locked", locked, lk);
        check("rnd_rail", err_rail, rl);
        check("rnd_mod", mod, it + 1);
      end
      abort_loop();
      check("rnd_stop_busy", busy, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dco_tune_ctrl.md
DCO_TUNE_CTRL -- requirements
Module: dco_tune_ctrl

Interface
REQ-001 SHALL have parameter WIN_LOG2, default 10, measurement window length of 2^WIN_LOG2 clk cycles.
REQ-002 SHALL have parameter TOL, default 2, lock tolerance in toggle counts.
REQ-003 SHALL have parameter LOCK_CNT, default 4, consecutive in-tolerance windows required for lock.
REQ-004 SHALL have parameter STEP_MAX, default 4096, maximum magnitude of one tuning step.
REQ-005 SHALL have parameter SETTLE_CYC, default 16, settle cycles after each tuning-word update.
REQ-006 clk  input  1  single clock for all logic.
REQ-007 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-008 cfg_valid  input  1  configuration request.
REQ-009 cfg_ready  output  1  controller idle and able to accept configuration.
REQ-010 cfg_mod  input  24  DCO modulus to program.
REQ-011 cfg_init_speed  input  24  initial DCO tuning word.
REQ-012 cfg_target  input  16  expected dco_in toggles per window.
REQ-013 stop  input  1  abort the tuning loop and return to idle.
REQ-014 dco_in  input  1  DCO output, synchronous to clk.
REQ-015 speed_var  output  24  tuning word driven to the DCO.
REQ-016 mod  output  24  modulus driven to the DCO.
REQ-017 locked  output  1  frequency within tolerance.
REQ-018 busy  output  1  loop running, i.e. any state other than IDLE.
REQ-019 err_rail  output  1  sticky flag: the tuning word was clamped at a rail.

Function
REQ-020 SHALL implement the states IDLE, SETTLE, MEASURE and ADJUST, with cfg_ready=1 only in IDLE.
REQ-021 SHALL, in IDLE on cfg_valid&&cfg_ready, load mod=cfg_mod, speed_var=cfg_init_speed and target=cfg_target, clear locked, err_rail and the in-lock counter, and enter SETTLE on the next edge.
REQ-022 SHALL ignore cfg_valid outside IDLE, leaving all registers unchanged.
REQ-023 SHALL remain in SETTLE for exactly SETTLE_CYC cycles, then enter MEASURE with the edge counter and window counter cleared.
REQ-024 SHALL register dco_in every cycle into dco_d (reset value 0), and in MEASURE SHALL count cycles with dco_in!=dco_d in a 16-bit counter that saturates at 0xFFFF.
REQ-025 SHALL remain in MEASURE for exactly 2^WIN_LOG2 cycles, then enter ADJUST.
REQ-026 SHALL, in ADJUST (1 cycle), compute the 17-bit signed value err = target - count.
REQ-027 SHALL, when |err|<=TOL, leave speed_var unchanged and increment the in-lock counter, saturating at LOCK_CNT.
REQ-028 SHALL, when |err|>TOL, clear the in-lock counter, deassert locked, and update speed_var += clamp(err, -STEP_MAX, +STEP_MAX) using a 26-bit signed sum.
REQ-029 SHALL clamp the updated speed_var to the range [1, 0xFFFFFF] and set err_rail when clamping occurs; the 0x000000 value is never driven.
REQ-030 SHALL assert locked on the edge that ends the ADJUST cycle in which the in-lock counter reaches LOCK_CNT.
REQ-031 SHALL enter SETTLE from ADJUST.
REQ-032 SHALL, on stop in any non-IDLE state, go to IDLE on the next edge and clear locked and the in-lock counter, while holding speed_var, mod and err_rail.
REQ-033 SHALL give stop priority over every other transition, and give rst priority over stop.
REQ-034 SHALL change mod only on configuration acceptance.

Reset
REQ-035 SHALL, on rst high at a clk edge, force state=IDLE, speed_var=0, mod=0, locked=0, busy=0, err_rail=0, cfg_ready=1, and all counters and dco_d to 0, including mid-operation.
REQ-036 SHALL hold the reset values while rst is high and SHALL accept no configuration during reset.

Verification
REQ-037 Lock: bench toggles dco_in every 8 cycles (128 toggles/window); configure target=128, init_speed=1000, mod=1000 -> speed_var stays 1000; locked=1 first seen 4*(16+1024+1) cycles after the accept edge.
REQ-038 Small step: count 128, target=200 -> after the first ADJUST speed_var=1072; locked=0; in-lock counter cleared.
REQ-039 Step clamp: count 128, target=10000 -> speed_var 1000->5096 (+4096); err_rail stays 0.
REQ-040 Rail: init_speed=0xFFFFF0, count 128, target=200 -> speed_var=0xFFFFFF, err_rail=1 and held until the next accept; with init_speed=5 and target=0 -> speed_var=1.
REQ-041 Abort/busy: cfg_valid pulsed during MEASURE is ignored; stop at MEASURE cycle 500 -> IDLE next edge, busy=0, cfg_ready=1, locked=0, speed_var/mod held.
REQ-042 Reset mid-loop: rst asserted in ADJUST -> next edge speed_var=0, mod=0, busy=0, cfg_ready=1, err_rail=0.
